// File: rtl/parquimetro_multicarril_pkg.sv
// Shared definitions for the multi-lane parking meter: lane state encodings,
// debounced sensor-pair constants and a small sizing helper.
package parquimetro_multicarril_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IN1   = 3'd1,
      IN2   = 3'd2,
      IN3   = 3'd3,
      OUT1  = 3'd4,
      OUT2  = 3'd5,
      OUT3  = 3'd6,
      ERROR = 3'd7
   } lane_state_t;

   // Sensor pair is always ordered {a, b}: a = street side, b = lot side.
   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_A    = 2'b10;
   localparam logic [1:0] S_B    = 2'b01;
   localparam logic [1:0] S_AB   = 2'b11;

   // Debounce counter only needs to reach DEB-1.
   function automatic int deb_cnt_width(input int deb);
      return (deb > 1) ? $clog2(deb) : 1;
   endfunction

endpackage

// File: rtl/parquimetro_multicarril_carril_fsm.sv
// One lane: two-flop synchronisers, a debouncer per beam and the direction FSM
// that turns the A/B beam sequence into entry/exit pulses.
module carril_fsm
   import parquimetro_multicarril_pkg::*;
#(
   parameter int DEB = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sens_a,
   input  logic sens_b,
   output logic entrada,
   output logic salida,
   output logic hubo_error
);

   localparam int            CW       = deb_cnt_width(DEB);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

   logic [1:0]    sync1, sync2, deb;
   logic [CW-1:0] deb_cnt [2];
   lane_state_t   state, state_next;
   logic          entrada_next, salida_next;

   // NOTE: sequential state always uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sens_a, sens_b};
         sync2 <= sync1;
      end
   end

   // A level is accepted on the DEB-th consecutive cycle it differs from deb.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_LAST) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         entrada <= 1'b0;
         salida  <= 1'b0;
      end else begin
         state   <= state_next;
         entrada <= entrada_next;
         salida  <= salida_next;
      end
   end

   // NOTE: defaults first so no path leaves a variable unassigned (no latches).
   always_comb begin
      state_next   = state;
      entrada_next = 1'b0;
      salida_next  = 1'b0;
      case (state)
         IDLE:
            case (deb)
               S_A:     state_next = IN1;
               S_B:     state_next = OUT1;
               S_AB:    state_next = ERROR;
               default: ;
            endcase
         IN1:
            case (deb)
               S_AB:    state_next = IN2;
               S_NONE:  state_next = IDLE;
               S_B:     state_next = ERROR;
               default: ;
            endcase
         IN2:
            case (deb)
               S_B:     state_next = IN3;
               S_A:     state_next = IN1;
               S_NONE:  state_next = ERROR;
               default: ;
            endcase
         IN3:
            case (deb)
               S_NONE: begin
                  state_next   = IDLE;
                  entrada_next = 1'b1;
               end
               S_AB:    state_next = IN2;
               S_A:     state_next = ERROR;
               default: ;
            endcase
         OUT1:
            case (deb)
               S_AB:    state_next = OUT2;
               S_NONE:  state_next = IDLE;
               S_A:     state_next = ERROR;
               default: ;
            endcase
         OUT2:
            case (deb)
               S_A:     state_next = OUT3;
               S_B:     state_next = OUT1;
               S_NONE:  state_next = ERROR;
               default: ;
            endcase
         OUT3:
            case (deb)
               S_NONE: begin
                  state_next  = IDLE;
                  salida_next = 1'b1;
               end
               S_AB:    state_next = OUT2;
               S_B:     state_next = ERROR;
               default: ;
            endcase
         ERROR:
            if (deb == S_NONE) state_next = IDLE;
      endcase
   end

   assign hubo_error = (state == ERROR);

endmodule

// File: rtl/parquimetro_multicarril.sv
// Multi-lane lot occupancy meter: one carril_fsm per lane feeding a shared
// saturating occupancy counter with a clamp-reject pulse.
module parquimetro_multicarril
   import parquimetro_multicarril_pkg::*;
#(
   parameter int LANES = 2,
   parameter int N     = 8,
   parameter int CAP   = 200,
   parameter int DEB   = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [LANES-1:0] sens_a,
   input  logic [LANES-1:0] sens_b,
   output logic [N-1:0]     conteo,
   output logic             lleno,
   output logic             vacio,
   output logic [LANES-1:0] entrada,
   output logic [LANES-1:0] salida,
   output logic             rechazo,
   output logic [LANES-1:0] hubo_error
);

   localparam int                   TW    = N + 4;
   localparam logic signed [TW-1:0] CAP_S = TW'(CAP);

   logic [3:0]           n_ent, n_sal;
   logic signed [TW-1:0] total;
   logic [N-1:0]         conteo_next;
   logic                 rechazo_next;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      carril_fsm #(.DEB(DEB)) u_carril (
         .clk        (clk),
         .reset_n    (reset_n),
         .sens_a     (sens_a[g]),
         .sens_b     (sens_b[g]),
         .entrada    (entrada[g]),
         .salida     (salida[g]),
         .hubo_error (hubo_error[g])
      );
   end

   // Signed headroom lets underflow and overflow be detected before clamping.
   always_comb begin
      n_ent = '0;
      n_sal = '0;
      for (int i = 0; i < LANES; i++) begin
         n_ent = n_ent + 4'(entrada[i]);
         n_sal = n_sal + 4'(salida[i]);
      end
      total        = $signed({4'b0000, conteo}) + $signed(TW'(n_ent)) - $signed(TW'(n_sal));
      conteo_next  = conteo;
      rechazo_next = 1'b0;
      if (total < 0) begin
         conteo_next  = '0;
         rechazo_next = 1'b1;
      end else if (total > CAP_S) begin
         conteo_next  = N'(CAP);
         rechazo_next = 1'b1;
      end else begin
         conteo_next  = total[N-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         conteo  <= '0;
         rechazo <= 1'b0;
      end else begin
         conteo  <= conteo_next;
         rechazo <= rechazo_next;
      end
   end

   assign lleno = (conteo == N'(CAP));
   assign vacio = (conteo == '0);

endmodule

// File: tb/tb_parquimetro_multicarril.sv
// Directed bench for parquimetro_multicarril (LANES=2, CAP=3, DEB=4): a vector
// table of lane sequences plus timed sequences for latency, simultaneity, glitches and reset.
module tb_parquimetro_multicarril;

   localparam int LANES = 2;
   localparam int N     = 8;
   localparam int CAP   = 3;
   localparam int DEB   = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [LANES-1:0] sens_a, sens_b;
   logic [N-1:0]     conteo;
   logic             lleno, vacio, rechazo;
   logic [LANES-1:0] entrada, salida, hubo_error;

   parquimetro_multicarril #(.LANES(LANES), .N(N), .CAP(CAP), .DEB(DEB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sens_a     (sens_a),
      .sens_b     (sens_b),
      .conteo     (conteo),
      .lleno      (lleno),
      .vacio      (vacio),
      .entrada    (entrada),
      .salida     (salida),
      .rechazo    (rechazo),
      .hubo_error (hubo_error)
   );

   always #5 clk = ~clk;

   int total_n = 0;
   int bad_n   = 0;

   // Pulse/event counters, updated just after each rising edge.
   int n_ent [2];
   int n_sal [2];
   int n_rej = 0;
   int n_err = 0;
   int se [2];
   int ss [2];
   int sr, serr;

   initial begin
      for (int i = 0; i < 2; i++) begin
         n_ent[i] = 0;
         n_sal[i] = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (entrada[i]) n_ent[i]++;
         if (salida[i])  n_sal[i]++;
      end
      if (rechazo)          n_rej++;
      if (hubo_error != 0)  n_err++;
   end

   typedef struct {
      string      name;
      logic [1:0] a;
      logic [1:0] b;
      int         conteo;
      logic [1:0] err;
      logic [1:0] ent;
      logic [1:0] sal;
      logic       rej;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic add(input string nm, input logic [1:0] a, input logic [1:0] b, input int c,
                      input logic [1:0] e, input logic [1:0] ent, input logic [1:0] sal,
                      input logic rej);
      vec_t v;
      v.name = nm; v.a = a; v.b = b; v.conteo = c;
      v.err = e; v.ent = ent; v.sal = sal; v.rej = rej;
      vecs.push_back(v);
   endtask

   task automatic add_entry(input string nm, input int lane, input int c0, input int c1,
                            input logic rej);
      logic [1:0] m;
      m = 2'b01 << lane;
      add({nm, ":A"},    m,     2'b00, c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":AB"},   m,     m,     c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":B"},    2'b00, m,     c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":none"}, 2'b00, 2'b00, c1, 2'b00, m,     2'b00, rej);
   endtask

   task automatic add_exit(input string nm, input int lane, input int c0, input int c1,
                           input logic rej);
      logic [1:0] m;
      m = 2'b01 << lane;
      add({nm, ":B"},    2'b00, m,     c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":AB"},   m,     m,     c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":A"},    m,     2'b00, c0, 2'b00, 2'b00, 2'b00, 1'b0);
      add({nm, ":none"}, 2'b00, 2'b00, c1, 2'b00, 2'b00, m,     rej);
   endtask

   task automatic drive(input logic [1:0] a, input logic [1:0] b);
      sens_a = a;
      sens_b = b;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      for (int i = 0; i < 2; i++) begin
         se[i] = n_ent[i];
         ss[i] = n_sal[i];
      end
      sr   = n_rej;
      serr = n_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Table contents, starting from conteo=1 after the timed first entry.
      add("backout1:A",    2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0);
      add("backout1:AB",   2'b10, 2'b10, 1, 2'b00, 2'b00, 2'b00, 1'b0);
      add("backout1:A2",   2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0);
      add("backout1:none", 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0);
      add("error0:AB",     2'b01, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1'b0);
      add("error0:none",   2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0);
      add_entry("in1_a", 1, 1, 2, 1'b0);
      add_entry("in1_b", 1, 2, 3, 1'b0);
      add_entry("in1_full", 1, 3, 3, 1'b1);
      add_exit("out0_a", 0, 3, 2, 1'b0);
      add_exit("out0_b", 0, 2, 1, 1'b0);
      add_exit("out0_c", 0, 1, 0, 1'b0);
      add_exit("out0_empty", 0, 0, 0, 1'b1);
      add_entry("in0_a", 0, 0, 1, 1'b0);
      add_entry("in0_b", 0, 1, 2, 1'b0);
      add_entry("in0_c", 0, 2, 3, 1'b0);

      // Reset state.
      reset_n = 1'b0;
      drive(2'b00, 2'b00);
      #1;
      check("rst conteo",     32'(conteo),     0);
      check("rst vacio",      32'(vacio),      1);
      check("rst lleno",      32'(lleno),      0);
      check("rst entrada",    32'(entrada),    0);
      check("rst salida",     32'(salida),     0);
      check("rst rechazo",    32'(rechazo),    0);
      check("rst hubo_error", 32'(hubo_error), 0);
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(2);

      // Lane 0 entry with exact pulse latency.
      drive(2'b01, 2'b00); wait_cyc(10);
      drive(2'b01, 2'b01); wait_cyc(10);
      drive(2'b00, 2'b01); wait_cyc(10);
      check("entry0 pre vacio", 32'(vacio), 1);
      drive(2'b00, 2'b00);
      wait_cyc(6);
      check("entry0 t6 entrada", 32'(entrada), 0);
      wait_cyc(1);
      check("entry0 t7 entrada", 32'(entrada), 32'(2'b01));
      check("entry0 t7 conteo",  32'(conteo),  0);
      wait_cyc(1);
      check("entry0 t8 entrada", 32'(entrada), 0);
      check("entry0 t8 conteo",  32'(conteo),  1);
      check("entry0 t8 vacio",   32'(vacio),   0);
      wait_cyc(2);

      // Vector table.
      for (int i = 0; i < vecs.size(); i++) begin
         snap();
         drive(vecs[i].a, vecs[i].b);
         wait_cyc(10);
         check($sformatf("%s conteo", vecs[i].name), 32'(conteo), 32'(vecs[i].conteo));
         check($sformatf("%s lleno", vecs[i].name), 32'(lleno), 32'(vecs[i].conteo == CAP));
         check($sformatf("%s vacio", vecs[i].name), 32'(vacio), 32'(vecs[i].conteo == 0));
         check($sformatf("%s hubo_error", vecs[i].name), 32'(hubo_error), 32'(vecs[i].err));
         for (int l = 0; l < 2; l++) begin
            check($sformatf("%s entrada%0d pulses", vecs[i].name, l),
                  32'(n_ent[l] - se[l]), 32'(vecs[i].ent[l]));
            check($sformatf("%s salida%0d pulses", vecs[i].name, l),
                  32'(n_sal[l] - ss[l]), 32'(vecs[i].sal[l]));
         end
         check($sformatf("%s rechazo pulses", vecs[i].name), 32'(n_rej - sr), 32'(vecs[i].rej));
      end

      // At CAP: lane 0 entry and lane 1 exit completing together.
      snap();
      drive(2'b01, 2'b10); wait_cyc(10);
      drive(2'b11, 2'b11); wait_cyc(10);
      drive(2'b10, 2'b01); wait_cyc(10);
      drive(2'b00, 2'b00);
      wait_cyc(7);
      check("simul entrada", 32'(entrada), 32'(2'b01));
      check("simul salida",  32'(salida),  32'(2'b10));
      wait_cyc(1);
      check("simul conteo",  32'(conteo),  CAP);
      check("simul rechazo", 32'(rechazo), 0);
      check("simul lleno",   32'(lleno),   1);
      wait_cyc(2);
      check("simul rechazo pulses", 32'(n_rej - sr), 0);
      check("simul entrada0 pulses", 32'(n_ent[0] - se[0]), 1);
      check("simul salida1 pulses",  32'(n_sal[1] - ss[1]), 1);

      // Short glitches must never reach the FSM.
      snap();
      for (int r = 0; r < 3; r++) begin
         drive(2'b01, 2'b00); wait_cyc(2);
         drive(2'b00, 2'b00); wait_cyc(2);
      end
      drive(2'b11, 2'b11); wait_cyc(2);
      drive(2'b00, 2'b00); wait_cyc(12);
      check("glitch error cycles", 32'(n_err - serr), 0);
      check("glitch entrada pulses", 32'(n_ent[0] + n_ent[1] - se[0] - se[1]), 0);
      check("glitch salida pulses",  32'(n_sal[0] + n_sal[1] - ss[0] - ss[1]), 0);
      check("glitch conteo", 32'(conteo), CAP);

      // Reset with lane 0 parked in IN2.
      drive(2'b01, 2'b00); wait_cyc(10);
      drive(2'b01, 2'b01); wait_cyc(10);
      reset_n = 1'b0;
      #1;
      check("midrst conteo",     32'(conteo),     0);
      check("midrst vacio",      32'(vacio),      1);
      check("midrst lleno",      32'(lleno),      0);
      check("midrst entrada",    32'(entrada),    0);
      check("midrst salida",     32'(salida),     0);
      check("midrst rechazo",    32'(rechazo),    0);
      check("midrst hubo_error", 32'(hubo_error), 0);
      drive(2'b00, 2'b01);
      wait_cyc(3);
      snap();
      reset_n = 1'b1;
      wait_cyc(10);
      drive(2'b00, 2'b00);
      wait_cyc(10);
      check("midrst after entrada pulses", 32'(n_ent[0] - se[0]), 0);
      check("midrst after salida pulses",  32'(n_sal[0] - ss[0]), 0);
      check("midrst after conteo",         32'(conteo), 0);
      check("midrst after hubo_error",     32'(hubo_error), 0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
